// File: rtl/lanes_frame_arbiter_if.sv
// AXI-Stream bundle of N byte lanes, each with its own tdest/tlast/tvalid/tready.
interface lanes_frame_arbiter_if #(
   parameter int unsigned N = 1
);
   logic [8*N-1:0] tdata;
   logic [8*N-1:0] tdest;
   logic [N-1:0]   tlast;
   logic [N-1:0]   tvalid;
   logic [N-1:0]   tready;

   modport master (output tdata, output tdest, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tdest, input tlast, input tvalid, output tready);
endinterface

// File: rtl/lanes_frame_arbiter.sv
// Frame-atomic round-robin merge of LANES byte streams into one registered
// stream, with a per-grant stall watchdog that terminates frames of stuck lanes.
module lanes_frame_arbiter #(
   parameter int unsigned LANES = 4
) (
   input  logic                  clk_core,
   input  logic                  clk_core_resn,
   lanes_frame_arbiter_if.slave  s_axis,
   lanes_frame_arbiter_if.master m_axis,
   input  logic [LANES-1:0]      cfg_lane_enable,
   input  logic [15:0]           cfg_stall_timeout,
   output logic [LANES-1:0]      status_grant,
   output logic                  stat_frame_done,
   output logic [LANES-1:0]      stat_timeout
);
   localparam int unsigned GW = $clog2(LANES);

   typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

   state_t             state;
   logic [GW-1:0]      g;
   logic [GW-1:0]      ptr;
   logic [GW-1:0]      next_g;
   logic [15:0]        stall_cnt;
   logic [7:0]         o_data;
   logic [7:0]         o_dest;
   logic               o_last;
   logic               o_valid;
   logic               load_ok;
   logic               timeout_hit;
   logic               found;
   logic               g_valid;
   logic               g_last;
   logic               g_take;
   logic [7:0]         g_data;
   logic [7:0]         g_dest;
   logic [LANES-1:0]   req;
   logic [2*LANES-1:0] req_dbl;
   int unsigned        cand;

   always_comb begin
      load_ok = !o_valid || m_axis.tready[0];
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      g_dest  = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (g == GW'(i)) begin
            g_valid = s_axis.tvalid[i];
            g_last  = s_axis.tlast[i];
            g_data  = s_axis.tdata[8*i +: 8];
            g_dest  = s_axis.tdest[8*i +: 8];
         end
      end
      timeout_hit = (state == GRANT) && (cfg_stall_timeout != '0) &&
                    (stall_cnt == cfg_stall_timeout);
      g_take = (state == GRANT) && !timeout_hit && load_ok && g_valid;

      // tready is withheld on the timeout cycle so no beat is accepted and then lost
      s_axis.tready = '0;
      status_grant  = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         status_grant[i]  = (state != IDLE) && (g == GW'(i));
         s_axis.tready[i] = (state == GRANT) && !timeout_hit && load_ok && (g == GW'(i));
      end
   end

   // Rotate requests so bit 0 is lane ptr+1; the first set bit is the next winner.
   always_comb begin
      req     = s_axis.tvalid & cfg_lane_enable;
      req_dbl = {req, req} >> ((GW+1)'(ptr) + (GW+1)'(1));
      found   = 1'b0;
      next_g  = ptr;
      cand    = 0;
      for (int unsigned j = 0; j < LANES; j++) begin
         if (!found && req_dbl[j]) begin
            found = 1'b1;
            cand  = 32'(ptr) + 32'd1 + j;
            if (cand >= LANES) cand = cand - LANES;
            next_g = GW'(cand);
         end
      end
   end

   always_ff @(posedge clk_core or negedge clk_core_resn) begin
      if (!clk_core_resn) begin
         state           <= IDLE;
         g               <= '0;
         ptr             <= GW'(LANES - 1);
         stall_cnt       <= '0;
         o_data          <= '0;
         o_dest          <= '0;
         o_last          <= 1'b0;
         o_valid         <= 1'b0;
         stat_frame_done <= 1'b0;
         stat_timeout    <= '0;
      end else begin
         stat_frame_done <= 1'b0;
         stat_timeout    <= '0;
         if (load_ok) o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  g         <= next_g;
                  ptr       <= next_g;
                  stall_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (timeout_hit) begin
                  stat_timeout[g] <= 1'b1;
                  state           <= FLUSH;
               end else if (g_take) begin
                  o_valid   <= 1'b1;
                  o_data    <= g_data;
                  o_dest    <= g_dest;
                  o_last    <= g_last;
                  stall_cnt <= '0;
                  if (g_last) begin
                     stat_frame_done <= 1'b1;
                     state           <= IDLE;
                  end
               end else if (!g_valid && stall_cnt != '1) begin
                  stall_cnt <= stall_cnt + 16'd1;
               end
            end
            FLUSH: begin
               // o_dest still holds the last tdest forwarded, which the terminator reuses
               if (load_ok) begin
                  o_valid <= 1'b1;
                  o_data  <= '0;
                  o_last  <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_axis.tdata  = o_data;
   assign m_axis.tdest  = o_dest;
   assign m_axis.tlast  = o_last;
   assign m_axis.tvalid = o_valid;
endmodule
